// File: rtl/instr_fetch_queue.sv
// In-order buffer of fetched {pc, instr} pairs feeding the decode stage.
// Presents a NOP with a zero PC whenever the queue is empty. A flush drops every entry.
module instr_fetch_queue #(
  parameter int          DEPTH = 4,
  parameter int          PC_W  = 32,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     if_valid,
  input  logic [31:0]              if_instr,
  input  logic [PC_W-1:0]          if_pc,
  output logic                     if_ready,
  output logic                     id_valid,
  output logic [31:0]              id_instr,
  output logic [PC_W-1:0]          id_pc,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]     instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push;
  logic          pop;

  // Ready depends only on registered occupancy, so a pop cannot free a slot for a push in the same cycle.
  assign if_ready = (count_reg != CW'(DEPTH));
  assign id_valid = (count_reg != '0);
  assign push     = if_valid & if_ready & ~flush;
  assign pop      = id_valid & id_ready & ~flush;
  assign count    = count_reg;

  assign id_instr = id_valid ? instr_mem[rd_ptr_reg] : NOP;
  assign id_pc    = id_valid ? pc_mem[rd_ptr_reg]    : '0;

  // Entry storage is never reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instr_mem[wr_ptr_reg] <= if_instr;
      pc_mem[wr_ptr_reg]    <= if_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= wr_ptr_reg;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a reference queue model checked every cycle.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            if_valid = 1'b0;
  logic [31:0]     if_instr = '0;
  logic [PC_W-1:0] if_pc = '0;
  logic            if_ready;
  logic            id_valid;
  logic [31:0]     id_instr;
  logic [PC_W-1:0] id_pc;
  logic            id_ready = 1'b0;
  logic [2:0]      count;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t sb_q[$];
  bit     model_known = 1'b0;
  int     checks = 0;
  int     failures = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .NOP(NOP_WORD)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
    .count(count)
  );

  function automatic logic [31:0] instr_of(input logic [PC_W-1:0] pc);
    return (pc * 32'd7919) ^ 32'hA5C0_0093;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model state for the current cycle.
  task automatic check_outputs();
    int n;
    n = sb_q.size();
    check("count", 64'(count), 64'(n));
    check("id_valid", 64'(id_valid), 64'(n != 0));
    check("if_ready", 64'(if_ready), 64'(n != DEPTH));
    if (n != 0) begin
      check("id_pc", 64'(id_pc), 64'(sb_q[0].pc));
      check("id_instr", 64'(id_instr), 64'(sb_q[0].instr));
    end else begin
      check("id_pc_empty", 64'(id_pc), 64'd0);
      check("id_instr_nop", 64'(id_instr), 64'(NOP_WORD));
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, update the model, take the rising edge.
  task automatic cycle(input bit r, input bit fl, input bit v, input logic [PC_W-1:0] pc, input bit rdy);
    bit do_push, do_pop;
    entry_t e;
    @(negedge clk);
    rst = r; flush = fl; if_valid = v; if_pc = pc; if_instr = instr_of(pc); id_ready = rdy;
    #1;
    if (model_known) check_outputs();
    do_push = v && (sb_q.size() != DEPTH);
    do_pop  = rdy && (sb_q.size() != 0);
    if (r) begin
      sb_q.delete();
      model_known = 1'b1;
    end else if (fl) begin
      sb_q.delete();
    end else begin
      if (do_pop) begin
        e = sb_q.pop_front();
        $display("ISSUE pc=%08h instr=%08h", e.pc, e.instr);
      end
      if (do_push) begin
        e.pc = pc; e.instr = instr_of(pc);
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
  endtask

  initial begin
    // 1: reset held two cycles while fetch offers data
    cycle(1, 0, 1, 32'h100, 0);
    cycle(1, 0, 1, 32'h104, 0);
    cycle(0, 0, 0, 0, 0);

    // 2: fill to DEPTH with decode stalled, fifth offer refused, head holds
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 32'(i * 4), 0);
    cycle(0, 0, 0, 0, 0);
    check("fill_count", 64'(count), 64'd4);
    check("fill_head", 64'(id_pc), 64'h0);

    // 3: streaming from empty, pointers wrap several times
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) cycle(0, 0, 1, 32'(i * 4), 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);

    // 4: full, single pop frees one slot, push refills
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 32'h200 + 32'(i * 4), 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 32'h210, 0);
    cycle(0, 0, 0, 0, 0);
    check("refill_count", 64'(count), 64'd4);

    // 5: flush with a concurrent push and pop, then the next push issues first
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h300 + 32'(i * 4), 0);
    cycle(0, 1, 1, 32'h30C, 1);
    cycle(0, 0, 1, 32'h400, 0);
    cycle(0, 0, 0, 0, 0);
    check("post_flush_head", 64'(id_pc), 64'h400);
    cycle(0, 0, 0, 0, 1);

    // 6: reset in the middle of streaming, then single-cycle fetch-to-issue
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 32'h500 + 32'(i * 4), 1);
    cycle(1, 0, 1, 32'h600, 1);
    cycle(0, 0, 1, 32'h700, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
